// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer, registered valid/ready
// on both sides, bubble zeroing and saturating stall/flush statistics.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q;
  logic              accept, pop, stall, discard;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign pop       = out_valid && out_ready;
  assign stall     = out_valid && !out_ready;
  // A popped head still completes downstream, so it is not counted as discarded.
  assign discard   = flush && (accept || (state_q == FULL) || ((state_q == ONE) && !pop));

  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign out_data  = out_valid ? main_data_q : '0;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= (state_d != FULL);
      if (stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (discard && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
